stack_sequencer: RTL and testbench

//  Command-driven push/pop/adjust engine for the bexkat1 core. It drives the

---
 rtl/stack_sequencer.sv | 152 +++++++++++++++
 tb/tb_stack_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// Push/pop/adjust engine for the bexkat1 stack: runs one Wishbone transfer per
// PUSH/POP and drives the register file write side for SP and POP destination.
module stack_sequencer #(
  parameter int unsigned       WIDTH   = 32,
  parameter int unsigned       COUNTP  = 4,
  parameter logic [COUNTP-1:0] SPREG   = COUNTP'(15),
  parameter int unsigned       TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [COUNTP-1:0] cmd_reg_i,
  input  logic [WIDTH-1:0]  cmd_data_i,
  input  logic [WIDTH-1:0]  sp_i,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [WIDTH-1:0]  bus_adr_o,
  output logic [3:0]        bus_sel_o,
  output logic [WIDTH-1:0]  bus_dat_o,
  input  logic [WIDTH-1:0]  bus_dat_i,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  output logic [COUNTP-1:0] wr_addr_o,
  output logic [WIDTH-1:0]  wr_data_o,
  output logic [1:0]        wr_en_o,
  output logic [WIDTH-1:0]  sp_data_o,
  output logic [1:0]        sp_en_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WB} state_t;
  typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_ADJ, OP_RSV} op_t;

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [COUNTP-1:0]   reg_q, reg_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0]    nsp_q, nsp_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                err_q, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_PUSH;
      reg_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      nsp_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      nsp_q   <= nsp_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    reg_d   = reg_q;
    data_d  = data_q;
    addr_d  = addr_q;
    nsp_d   = nsp_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d   = op_t'(cmd_op_i);
          reg_d  = cmd_reg_i;
          data_d = cmd_data_i;
          cnt_d  = '0;
          unique case (op_t'(cmd_op_i))
            OP_PUSH: begin
              addr_d  = sp_i - FOUR;
              nsp_d   = sp_i - FOUR;
              state_d = S_BUS;
            end
            OP_POP: begin
              addr_d  = sp_i;
              nsp_d   = sp_i + FOUR;
              state_d = S_BUS;
            end
            OP_ADJ: begin
              nsp_d   = sp_i + cmd_data_i;
              state_d = S_WB;
            end
            OP_RSV: err_d = 1'b1;
          endcase
        end
      end
      S_BUS: begin
        // err takes priority over a simultaneous ack
        if (bus_err_i) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (bus_ack_i) begin
          rdata_d = bus_dat_i;
          state_d = S_WB;
        end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic in_bus, in_wb, pop_to_sp;

  always_comb begin
    in_bus      = (state_q == S_BUS);
    in_wb       = (state_q == S_WB);
    pop_to_sp   = (op_q == OP_POP) && (reg_q == SPREG);
    cmd_ready_o = (state_q == S_IDLE) && !rst_i;
    bus_cyc_o   = in_bus;
    bus_stb_o   = in_bus;
    bus_we_o    = in_bus && (op_q == OP_PUSH);
    bus_adr_o   = addr_q;
    bus_sel_o   = 4'hF;
    bus_dat_o   = data_q;
    wr_addr_o   = reg_q;
    wr_data_o   = rdata_q;
    wr_en_o     = (in_wb && op_q == OP_POP && !pop_to_sp) ? 2'h3 : 2'h0;
    sp_data_o   = pop_to_sp ? rdata_q : nsp_q;
    sp_en_o     = in_wb ? 2'h3 : 2'h0;
    done_o      = in_wb;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed cases plus random commands checked
// against a stack-memory / SP model.
module tb_stack_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [3:0]  cmd_reg_i;
  logic [31:0] cmd_data_i, sp_i;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i, bus_err_i;
  logic [3:0]  wr_addr_o;
  logic [31:0] wr_data_o, sp_data_o;
  logic [1:0]  wr_en_o, sp_en_o;
  logic        done_o, err_o;

  always #5 clk_i = ~clk_i;

  stack_sequencer #(.WIDTH(32), .COUNTP(4), .SPREG(4'd15), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_reg_i(cmd_reg_i), .cmd_data_i(cmd_data_i), .sp_i(sp_i),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_adr_o(bus_adr_o), .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o),
    .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_en_o(wr_en_o),
    .sp_data_o(sp_data_o), .sp_en_o(sp_en_o), .done_o(done_o), .err_o(err_o)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] sp_model;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // mode: 0 = ack after delay, 1 = bus error after delay, 2 = never respond
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] rg, input logic [31:0] d,
                        input int unsigned delay, input int unsigned mode,
                        input logic [31:0] rval, input bit hold);
    logic [31:0] ea, en;
    int unsigned cycles;
    ea = '0;
    en = '0;
    chk("ready_idle", {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_reg_i   = rg;
    cmd_data_i  = d;
    sp_i        = sp_model;
    tick();
    if (!hold || op >= 2'd2) cmd_valid_i = 1'b0;
    case (op)
      2'd0:    begin ea = sp_model - 32'd4; en = sp_model - 32'd4; end
      2'd1:    begin ea = sp_model;         en = sp_model + 32'd4; end
      2'd2:    en = sp_model + d;
      default: ;
    endcase
    if (op == 2'd3) begin
      chk("rsv_err", {31'd0, err_o}, 32'd1);
      chk("rsv_done", {31'd0, done_o}, 32'd0);
      chk("rsv_cyc", {31'd0, bus_cyc_o}, 32'd0);
      tick();
      chk("rsv_err_clear", {31'd0, err_o}, 32'd0);
      return;
    end
    if (op == 2'd2) begin
      chk("adj_done", {31'd0, done_o}, 32'd1);
      chk("adj_sp_en", {30'd0, sp_en_o}, 32'd3);
      chk("adj_sp_data", sp_data_o, en);
      chk("adj_wr_en", {30'd0, wr_en_o}, 32'd0);
      chk("adj_cyc", {31'd0, bus_cyc_o}, 32'd0);
      sp_model = en;
      tick();
      chk("adj_done_clear", {31'd0, done_o}, 32'd0);
      chk("adj_sp_en_clear", {30'd0, sp_en_o}, 32'd0);
      return;
    end
    cycles = (mode == 2) ? 4 : delay + 1;
    for (int k = 0; k < int'(cycles); k++) begin
      chk("bus_cyc", {31'd0, bus_cyc_o}, 32'd1);
      chk("bus_stb", {31'd0, bus_stb_o}, 32'd1);
      chk("bus_we", {31'd0, bus_we_o}, (op == 2'd0) ? 32'd1 : 32'd0);
      chk("bus_adr", bus_adr_o, ea);
      chk("bus_sel", {28'd0, bus_sel_o}, 32'hF);
      chk("bus_ready", {31'd0, cmd_ready_o}, 32'd0);
      chk("bus_done", {31'd0, done_o}, 32'd0);
      if (op == 2'd0) chk("bus_dat_o", bus_dat_o, d);
      if (k == int'(cycles) - 1) begin
        cmd_valid_i = 1'b0;
        if (mode == 0) begin
          bus_ack_i = 1'b1;
          bus_dat_i = rval;
        end else if (mode == 1) begin
          bus_err_i = 1'b1;
          bus_ack_i = 1'($urandom_range(0, 1));
        end
      end
      tick();
      bus_ack_i = 1'b0;
      bus_err_i = 1'b0;
      bus_dat_i = $urandom;
    end
    if (mode != 0) begin
      chk("abort_err", {31'd0, err_o}, 32'd1);
      chk("abort_sp_en", {30'd0, sp_en_o}, 32'd0);
      chk("abort_wr_en", {30'd0, wr_en_o}, 32'd0);
      chk("abort_done", {31'd0, done_o}, 32'd0);
      chk("abort_cyc", {31'd0, bus_cyc_o}, 32'd0);
      tick();
      chk("abort_err_clear", {31'd0, err_o}, 32'd0);
      chk("abort_sp_en_later", {30'd0, sp_en_o}, 32'd0);
      return;
    end
    chk("wb_done", {31'd0, done_o}, 32'd1);
    chk("wb_cyc", {31'd0, bus_cyc_o}, 32'd0);
    chk("wb_sp_en", {30'd0, sp_en_o}, 32'd3);
    if (op == 2'd0) begin
      chk("push_sp_data", sp_data_o, en);
      chk("push_wr_en", {30'd0, wr_en_o}, 32'd0);
      mem[ea]  = d;
      sp_model = en;
    end else if (rg == 4'd15) begin
      chk("popsp_sp_data", sp_data_o, rval);
      chk("popsp_wr_en", {30'd0, wr_en_o}, 32'd0);
      sp_model = rval;
    end else begin
      chk("pop_wr_en", {30'd0, wr_en_o}, 32'd3);
      chk("pop_wr_addr", {28'd0, wr_addr_o}, {28'd0, rg});
      chk("pop_wr_data", wr_data_o, rval);
      chk("pop_sp_data", sp_data_o, en);
      sp_model = en;
    end
    tick();
    chk("post_done", {31'd0, done_o}, 32'd0);
    chk("post_sp_en", {30'd0, sp_en_o}, 32'd0);
    chk("post_wr_en", {30'd0, wr_en_o}, 32'd0);
    chk("post_err", {31'd0, err_o}, 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] d, rval;
    int unsigned r, mode;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_reg_i = '0;
    cmd_data_i = '0; sp_i = '0; bus_dat_i = '0; bus_ack_i = 1'b0; bus_err_i = 1'b0;
    #1;
    chk("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
    chk("rst_cyc", {31'd0, bus_cyc_o}, 32'd0);
    chk("rst_adr", bus_adr_o, 32'd0);
    chk("rst_sp_en", {30'd0, sp_en_o}, 32'd0);
    chk("rst_sp_data", sp_data_o, 32'd0);
    chk("rst_wr_en", {30'd0, wr_en_o}, 32'd0);
    chk("rst_wr_data", wr_data_o, 32'd0);
    chk("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    sp_model = 32'h1000;
    do_cmd(2'd0, 4'd0, 32'hDEADBEEF, 2, 0, 32'd0, 1'b0);
    do_cmd(2'd1, 4'd3, 32'd0, 0, 0, 32'h12345678, 1'b0);
    do_cmd(2'd1, 4'd15, 32'd0, 1, 0, 32'h2000, 1'b0);
    sp_model = 32'd0;
    do_cmd(2'd0, 4'd0, 32'h0000_0005, 0, 0, 32'd0, 1'b0);
    do_cmd(2'd0, 4'd1, 32'hAAAA_5555, 1, 1, 32'd0, 1'b0);
    do_cmd(2'd1, 4'd2, 32'd0, 0, 2, 32'd0, 1'b0);
    do_cmd(2'd0, 4'd0, 32'h55, 2, 0, 32'd0, 1'b1);
    do_cmd(2'd3, 4'd0, 32'd0, 0, 0, 32'd0, 1'b0);
    sp_model = 32'h1000;
    do_cmd(2'd2, 4'd0, 32'hFFFF_FFF0, 0, 0, 32'd0, 1'b0);
    chk("adj_result", sp_model, 32'h0FF0);

    // reset asserted while a PUSH is on the bus
    cmd_valid_i = 1'b1; cmd_op_i = 2'd0; cmd_data_i = 32'h77; sp_i = sp_model;
    tick();
    cmd_valid_i = 1'b0;
    chk("midrst_cyc_before", {31'd0, bus_cyc_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("midrst_cyc", {31'd0, bus_cyc_o}, 32'd0);
    chk("midrst_stb", {31'd0, bus_stb_o}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_quiet", {26'd0, done_o, err_o, sp_en_o, wr_en_o}, 32'd0);
    end

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      d = (op == 2'd2) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom;
      r = $urandom_range(0, 19);
      mode = (r == 0) ? 2 : (r < 3) ? 1 : 0;
      rval = mem.exists(sp_model) ? mem[sp_model] : $urandom;
      do_cmd(op, 4'($urandom_range(0, 15)), d, $urandom_range(0, 2), mode, rval,
             1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
